aes_round_engine: RTL

Iterative AES-128 encryption datapath that sits directly downstream of `AES_key_memory`. It accepts one 128-bit plaintext block per valid/ready handshake and steps the key memory's `round` select one round ahead of use, because the key memory registers its output. It performs AddRoundKey plus ten rounds at one round per cycle and presents the ciphertext on a valid/ready output.

---
 rtl/aes_round_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryption, one round per cycle.
// This unit sits directly after AES_key_memory. The key memory registers its output, so the
// engine drives `round` one round ahead of the round in which it uses that key.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   plaintext handshake; a block is accepted only in IDLE
//   plaintext[127:0]      input block, byte 0 in [127:120], column-major
//   round[3:0]            registered round-key index sent to the key memory
//   round_key[127:0]      key memory output, K[round of previous cycle]
//   out_valid / out_ready ciphertext handshake
//   ciphertext[127:0]     result, updated only on entry to DONE
//   busy                  high while a block is in flight (WAIT, RND)

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry i sits at bits [2047-8i -: 8].
  localparam logic [2047:0] Table = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = Table[11'd2047 - {din, 3'b000} -: 8];

endmodule

module aes_round_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [2:0] {StPrime, StIdle, StWait, StRnd, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [3:0]   round_q, round_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] sub_blk;
  logic [127:0] sr_blk;
  logic [127:0] mc_blk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // 2a0^3a1^a2^a3 rewritten as a0 ^ (a0^a1^a2^a3) ^ xtime(a0^a1), and rotations thereof.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    sbox u_sbox (
      .din  (st_q[127 - 8*k -: 8]),
      .dout (sub_blk[127 - 8*k -: 8])
    );
  end

  assign sr_blk = shift_rows(sub_blk);
  assign mc_blk = mix_columns(sr_blk);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    ct_d        = ct_q;
    rcnt_d      = rcnt_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      // Gives the unreset key memory one edge to load K0 before the first accept.
      StPrime: begin
        round_d = 4'd0;
        state_d = StIdle;
      end
      StIdle: begin
        round_d = 4'd0;
        if (in_valid) begin
          st_d    = plaintext ^ round_key;
          round_d = 4'd1;
          rcnt_d  = 4'd1;
          state_d = StWait;
        end
      end
      // Bubble while the key memory fetches K1.
      StWait: begin
        round_d = 4'd2;
        state_d = StRnd;
      end
      StRnd: begin
        // Request two rounds ahead; park at 0 so K0 is ready for the next block.
        round_d = (rcnt_q <= 4'd8) ? rcnt_q + 4'd2 : 4'd0;
        if (rcnt_q == 4'd10) begin
          st_d        = sr_blk ^ round_key;
          ct_d        = sr_blk ^ round_key;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          st_d   = mc_blk ^ round_key;
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StPrime;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPrime;
      st_q        <= '0;
      ct_q        <= '0;
      rcnt_q      <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      ct_q        <= ct_d;
      rcnt_q      <= rcnt_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q == StWait) || (state_q == StRnd);
  assign round      = round_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

endmodule
